uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of sample_tick pulses per bit period; legal value 16 only.
REQ-002 Parameter SYNC_STAGES, default 2: number of flip-flops synchronising the rx input.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low: assertion forces reset state immediately, release is synchronous to clk.
REQ-005 sample_tick  input  1  one-clk-wide enable pulse at 16x baud rate, generated by the shared baud generator.
REQ-006 rx  input  1  asynchronous serial line, idle high; same framing as the transmitter (1 start, 8 data LSB first, 1 stop).
REQ-007 dout  output  8  last correctly received byte; held stable until the next good frame.
REQ-008 dout_rdy  output  1  one-clk pulse when dout is updated with a good frame.
REQ-009 frame_err  output  1  one-clk pulse when a frame's stop bit samples low.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 The block SHALL synchronise rx through SYNC_STAGES flops; all decisions use the synchronised value rx_s only.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and REARM; the tick counter (4 bits) and bit counter (3 bits) advance only on sample_tick.
REQ-013 IDLE: when rx_s is low on a sample_tick, go to START with the tick counter at 0.
REQ-014 Each bit SHALL be decided by a 2-of-3 majority of rx_s taken at tick counts 7, 8 and 9; the decision is made at tick 9; the counter wraps 15->0 at the bit boundary.
REQ-015 START: a majority of 0 means the start bit is valid; the FSM waits for the wrap and then enters DATA with bit counter 0. A majority of 1 is a glitch; the FSM returns to IDLE with no output pulse.
REQ-016 DATA: each majority bit SHALL be shifted into an 8-bit shift register from the MSB side (LSB first on the line); after bit 7's wrap, enter STOP.
REQ-017 STOP, majority 1: load dout from the shift register, pulse dout_rdy on the next clk, and return to IDLE at tick 9 without waiting for the wrap, so the next start edge is caught.
REQ-018 STOP, majority 0: pulse frame_err, leave dout unchanged, go to REARM.
REQ-019 REARM: stay until rx_s is high on a sample_tick, then go to IDLE; a held-low line (break) therefore yields exactly one frame_err.
REQ-020 Latency: dout_rdy SHALL rise exactly 1 clk after the sample_tick at stop-bit tick 9.
REQ-021 dout_rdy and frame_err SHALL never be high in the same cycle.
REQ-022 sample_tick absent: the FSM and counters hold; a level change on rx alone causes no transition.

Reset
REQ-023 On rst low: state IDLE, counters 0, shift register 0, dout 0x00, dout_rdy 0, frame_err 0, busy 0, synchroniser flops 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse on dout_rdy or frame_err; reception resumes on the first start edge after release.

Structure
REQ-025 The shared uart package SHALL hold the FSM state encoding, the OVERSAMPLE constant, the data width (8), the START_BIT/STOP_BIT levels, and the majority tick indices (7, 8, 9).
REQ-026 One sub-module, uart_rx_sync (SYNC_STAGES-deep synchroniser with idle-high reset), SHALL be instantiated; all other logic lives in uart_rx.

Verification
REQ-027 Frame 0x55 at 16 ticks/bit -> dout=0x55, one dout_rdy pulse 1 clk after stop tick 9, frame_err stays 0.
REQ-028 rx low for 4 ticks only, then high -> FSM returns to IDLE from START; no dout_rdy or frame_err pulse; dout unchanged.
REQ-029 Frame 0xA5 with stop bit low, then line high -> one frame_err pulse; dout retains its previous value (0x55); REARM then IDLE.
REQ-030 Frames 0x01 and 0xFE back-to-back with zero idle time after the stop bit -> two dout_rdy pulses, dout=0x01 then 0xFE.
REQ-031 rst pulled low during data bit 4 of frame 0x3C, released, then frame 0xC3 sent -> only 0xC3 is received; no pulse during the aborted frame.
REQ-032 Line held low for 30 bit times, then released -> exactly one frame_err; the next frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants, state encoding and helpers for the UART
// receiver.
//   OVERSAMPLE     sample_tick pulses per bit period
//   DATA_W         payload width
//   START_BIT /
//   STOP_BIT       line levels that frame a byte
//   MAJ_T0..T2     tick-counter values at which a bit is sampled
package uart_rx_pkg;

  localparam int         OVERSAMPLE = 16;
  localparam int         DATA_W     = 8;
  localparam logic       START_BIT  = 1'b0;
  localparam logic       STOP_BIT   = 1'b1;
  localparam logic [3:0] MAJ_T0     = 4'd7;
  localparam logic [3:0] MAJ_T1     = 4'd8;
  localparam logic [3:0] MAJ_T2     = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_REARM
  } rx_state_t;

  // 2-of-3 vote used to decide each bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the receiver's tick/line inputs and byte outputs.
//   i_sample_tick  16x baud enable pulse
//   i_rx           serial line, idle high
//   o_dout         last good byte
//   o_dout_rdy     one-clk pulse on a good frame
//   o_frame_err    one-clk pulse on a low stop bit
//   o_busy         receiver not idle
// slave = receiver side, master = driver/observer side.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic              i_sample_tick;
  logic              i_rx;
  logic [DATA_W-1:0] o_dout;
  logic              o_dout_rdy;
  logic              o_frame_err;
  logic              o_busy;

  modport slave (
    input  i_sample_tick, i_rx,
    output o_dout, o_dout_rdy, o_frame_err, o_busy
  );

  modport master (
    output i_sample_tick, i_rx,
    input  o_dout, o_dout_rdy, o_frame_err, o_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep flop chain bringing the asynchronous rx
// line into the clk domain. Flops reset to 1 so a reset never looks like a
// start edge.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_rx        raw serial line
//   o_rx_s      synchronised line
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_s
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   w_chain;

  // Chain of the raw input followed by every stage; the top bit is the output.
  assign w_chain = {r_sync, i_rx};
  assign o_rx_s  = w_chain[SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= w_chain[SYNC_STAGES-1:0];
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and 2-of-3 majority
// bit decisions at tick counts 7, 8 and 9.
//   clk    system clock
//   rst_n  asynchronous active-low reset, released synchronously
//   bus    uart_rx_if.slave: sample_tick/rx in; dout, dout_rdy, frame_err,
//          busy out
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = uart_rx_pkg::OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);

  rx_state_t         r_state, w_state_next;
  logic [3:0]        r_tick_cnt, w_tick_next;
  logic [2:0]        r_bit_cnt, w_bit_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic [DATA_W-1:0] r_dout, w_dout_next;
  logic              r_s7, w_s7_next;
  logic              r_s8, w_s8_next;
  logic              r_dout_rdy, w_rdy_next;
  logic              r_frame_err, w_err_next;
  logic              w_rx_s;
  logic              w_maj;
  logic              w_wrap;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (bus.i_rx),
    .o_rx_s (w_rx_s)
  );

  // Third vote is the live sample, so the decision lands on tick 9 itself.
  assign w_maj  = maj3(r_s7, r_s8, w_rx_s);
  assign w_wrap = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_dout_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tick_cnt  <= w_tick_next;
      r_bit_cnt   <= w_bit_next;
      r_shift     <= w_shift_next;
      r_dout      <= w_dout_next;
      r_s7        <= w_s7_next;
      r_s8        <= w_s8_next;
      r_dout_rdy  <= w_rdy_next;
      r_frame_err <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick_cnt;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_dout_next  = r_dout;
    w_s7_next    = r_s7;
    w_s8_next    = r_s8;
    w_rdy_next   = 1'b0;
    w_err_next   = 1'b0;

    if (bus.i_sample_tick) begin
      if (r_tick_cnt == MAJ_T0) w_s7_next = w_rx_s;
      if (r_tick_cnt == MAJ_T1) w_s8_next = w_rx_s;
      w_tick_next = w_wrap ? 4'd0 : r_tick_cnt + 4'd1;

      unique case (r_state)
        ST_IDLE: begin
          w_tick_next = '0;
          w_bit_next  = '0;
          if (w_rx_s == START_BIT) w_state_next = ST_START;
        end
        ST_START: begin
          if (r_tick_cnt == MAJ_T2 && w_maj != START_BIT) begin
            w_state_next = ST_IDLE;
            w_tick_next  = '0;
          end else if (w_wrap) begin
            w_state_next = ST_DATA;
            w_bit_next   = '0;
          end
        end
        ST_DATA: begin
          if (r_tick_cnt == MAJ_T2) w_shift_next = {w_maj, r_shift[DATA_W-1:1]};
          if (w_wrap) begin
            if (r_bit_cnt == BIT_LAST) w_state_next = ST_STOP;
            else                       w_bit_next   = r_bit_cnt + 3'd1;
          end
        end
        ST_STOP: begin
          // Leave at tick 9 rather than the wrap so a back-to-back start
          // edge is not missed.
          if (r_tick_cnt == MAJ_T2) begin
            w_tick_next = '0;
            if (w_maj == STOP_BIT) begin
              w_dout_next  = r_shift;
              w_rdy_next   = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = ST_REARM;
            end
          end
        end
        ST_REARM: begin
          w_tick_next = '0;
          if (w_rx_s == STOP_BIT) w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_tick_next  = '0;
        end
      endcase
    end
  end

  assign bus.o_dout      = r_dout;
  assign bus.o_dout_rdy  = r_dout_rdy;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; a scoreboard queue holds the
// expected event (good byte or framing error, dout value, cycle) and a
// monitor pops and compares on every dout_rdy/frame_err pulse.
module tb_uart_rx;
  import uart_rx_pkg::*;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic [1:0] tdiv = 2'd0;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_bad = 0;
  logic [7:0] last_good = 8'h00;
  exp_t   sb_q[$];

  uart_rx_if bus();

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One tick every 4 clocks, changed on the falling edge.
  initial bus.i_sample_tick = 1'b0;
  always @(negedge clk) begin
    tdiv <= tdiv + 2'd1;
    bus.i_sample_tick <= (tdiv == 2'd0);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end else begin
      $display("check %s: 0x%02h ok", name, act);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!bus.i_sample_tick);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    bus.i_rx = v;
    repeat (n) wait_tick();
  endtask

  task automatic push_exp(input bit is_err, input logic [7:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.cyc    = cyc;
    sb_q.push_back(e);
  endtask

  // Receiver's stop-bit decision (tick count 9) lands on line tick 11 of the
  // stop bit: tick 1 is seen in IDLE, tick 2 is count 0.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    hold(START_BIT, 16);
    for (int i = 0; i < 8; i++) hold(b[i], 16);
    hold(stop_lvl, 11);
    if (stop_lvl) begin
      push_exp(1'b0, b);
      last_good = b;
    end else begin
      push_exp(1'b1, last_good);
    end
    hold(stop_lvl, 5);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (bus.o_dout_rdy || bus.o_frame_err) begin
      n_vec++;
      if (bus.o_dout_rdy && bus.o_frame_err) begin
        n_bad++;
        $display("FAIL exclusive_pulses: dout_rdy=1 frame_err=1 at cycle %0d, required not both", cyc);
      end else if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: rdy=%0b err=%0b dout=0x%02h at cycle %0d, required no pulse",
                 bus.o_dout_rdy, bus.o_frame_err, bus.o_dout, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (bus.o_frame_err !== e.is_err || bus.o_dout !== e.data || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL rx_event: err=%0b dout=0x%02h cycle=%0d, required err=%0b dout=0x%02h cycle=%0d",
                   bus.o_frame_err, bus.o_dout, cyc, e.is_err, e.data, e.cyc);
        end else begin
          $display("rx event: %s dout=0x%02h cycle=%0d ok",
                   e.is_err ? "frame_err" : "dout_rdy", e.data, cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    bus.i_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_dout", bus.o_dout, 8'h00);
    check("reset_rdy", {7'd0, bus.o_dout_rdy}, 8'h00);
    check("reset_err", {7'd0, bus.o_frame_err}, 8'h00);
    check("reset_busy", {7'd0, bus.o_busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 32);

    // Good frame 0x55.
    send_frame(8'h55, 1'b1);
    hold(1'b1, 16);

    // 4-tick glitch: START then back to IDLE, no pulse.
    hold(1'b0, 4);
    check("glitch_busy_during", {7'd0, bus.o_busy}, 8'h01);
    hold(1'b1, 16);
    check("glitch_busy_after", {7'd0, bus.o_busy}, 8'h00);
    check("glitch_dout", bus.o_dout, 8'h55);

    // 0xA5 with low stop bit -> frame_err, dout keeps 0x55, REARM then IDLE.
    send_frame(8'hA5, 1'b0);
    check("rearm_busy", {7'd0, bus.o_busy}, 8'h01);
    hold(1'b1, 4);
    check("rearm_exit_busy", {7'd0, bus.o_busy}, 8'h00);
    hold(1'b1, 16);

    // Back-to-back frames with no idle time.
    send_frame(8'h01, 1'b1);
    send_frame(8'hFE, 1'b1);
    hold(1'b1, 16);

    // Reset during data bit 4 of 0x3C.
    hold(START_BIT, 16);
    for (int i = 0; i < 4; i++) hold(logic'((8'h3C >> i) & 8'h01), 16);
    hold(1'b1, 5);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {7'd0, bus.o_busy}, 8'h00);
    check("midreset_dout", bus.o_dout, 8'h00);
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 48);
    send_frame(8'hC3, 1'b1);
    hold(1'b1, 16);

    // Break: 30 bit times low -> exactly one frame_err.
    bus.i_rx = 1'b0;
    repeat (9 * 16 + 11) wait_tick();
    push_exp(1'b1, last_good);
    repeat (30 * 16 - (9 * 16 + 11)) wait_tick();
    check("break_busy", {7'd0, bus.o_busy}, 8'h01);
    hold(1'b1, 32);
    check("break_exit_busy", {7'd0, bus.o_busy}, 8'h00);
    send_frame(8'h7E, 1'b1);
    hold(1'b1, 32);

    check("final_dout", bus.o_dout, 8'h7E);
    check("scoreboard_drained", 8'(sb_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
